// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared encodings for the program-counter sequencer
package pc_seq_pkg;

  // Opcode encoding presented by instruction decode
  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_SKIP = 3'd1,
    OP_BRF  = 3'd2,
    OP_BRB  = 3'd3,
    OP_JABS = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } op_t;

  // Branch condition selector, evaluated against the ALU flags
  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_ZERO   = 2'd1,
    COND_NEG    = 2'd2,
    COND_POS    = 2'd3
  } cond_t;

  // Sequencer state register encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_HALT  = 2'd1;
  localparam state_t ST_FAULT = 2'd2;

  // Branch condition from selector and flags; POS means strictly positive
  function automatic logic eval_cond(input cond_t sel, input logic zero, input logic neg);
    logic c;
    case (sel)
      COND_ALWAYS: c = 1'b1;
      COND_ZERO:   c = zero;
      COND_NEG:    c = neg;
      COND_POS:    c = ~zero & ~neg;
      default:     c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - hardware return-address LIFO for CALL/RET
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4,
  localparam int DEPTH_W  = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  push_data,
  output logic [ADDR_W-1:0]  top,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W-1:0] depth
);

  logic [ADDR_W-1:0]  mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0]  mem_d [RAS_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;

  assign full  = (depth_q == DEPTH_W'(RAS_DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  // Top-of-stack read: entry at index depth-1, zero when empty
  always_comb begin
    top = '0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) top = mem_q[i];
    end
  end

  // Next stack contents and depth; caller guarantees no push when full, no pop when empty
  always_comb begin
    depth_d = depth_q;
    for (int i = 0; i < RAS_DEPTH; i++) mem_d[i] = mem_q[i];
    if (push && !full) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (depth_q == DEPTH_W'(i)) mem_d[i] = push_data;
      end
      depth_d = depth_q + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  // Depth register; reset discards the stack by emptying it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Entry storage needs no reset since depth gates every read
  always_ff @(posedge clock) begin
    for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, next-PC logic, halt/fault FSM and return stack
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter int              OFFS_W    = 4,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int             DEPTH_W   = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [2:0]         op,
  input  logic [1:0]         cond_sel,
  input  logic               zero,
  input  logic               neg,
  input  logic [OFFS_W-1:0]  offset,
  input  logic [ADDR_W-1:0]  target,
  input  logic               resume,
  output logic [ADDR_W-1:0]  pc,
  output logic               taken,
  output logic               halted,
  output logic               fault,
  output logic [DEPTH_W-1:0] stack_depth
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  state_t            state_q, state_d;

  logic              cond;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] offs_ext;
  logic              rs_push, rs_pop, rs_full, rs_empty;
  logic [ADDR_W-1:0] rs_top;

  assign cond     = eval_cond(cond_t'(cond_sel), zero, neg);
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign offs_ext = ADDR_W'(offset);

  ret_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ret_stack (
    .clock    (clock),
    .reset    (reset),
    .push     (rs_push),
    .pop      (rs_pop),
    .push_data(pc_inc),
    .top      (rs_top),
    .full     (rs_full),
    .empty    (rs_empty),
    .depth    (stack_depth)
  );

  // Next PC, taken flag, state and stack commands; enable=0 or FAULT holds everything
  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    state_d = state_q;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    if (enable) begin
      case (state_q)
        ST_RUN: begin
          taken_d = 1'b0;
          pc_d    = pc_inc;
          case (op_t'(op))
            OP_SEQ: ;
            OP_SKIP: if (cond) begin
              pc_d    = pc_q + ADDR_W'(2);
              taken_d = 1'b1;
            end
            OP_BRF: if (cond) begin
              pc_d    = pc_q + offs_ext;
              taken_d = 1'b1;
            end
            OP_BRB: if (cond) begin
              pc_d    = pc_q - offs_ext;
              taken_d = 1'b1;
            end
            OP_JABS: if (cond) begin
              pc_d    = target;
              taken_d = 1'b1;
            end
            OP_CALL: begin
              if (rs_full) begin
                pc_d    = pc_q;
                state_d = ST_FAULT;
              end else begin
                rs_push = 1'b1;
                pc_d    = target;
                taken_d = 1'b1;
              end
            end
            OP_RET: begin
              if (rs_empty) begin
                pc_d    = pc_q;
                state_d = ST_FAULT;
              end else begin
                rs_pop  = 1'b1;
                pc_d    = rs_top;
                taken_d = 1'b1;
              end
            end
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
            default: ;
          endcase
        end
        ST_HALT: begin
          if (resume) begin
            pc_d    = pc_inc;
            taken_d = 1'b0;
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // PC, taken and state registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      state_q <= state_d;
    end
  end

  assign pc     = pc_q;
  assign taken  = taken_q;
  assign halted = (state_q == ST_HALT);
  assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] op = 3'd0;
  logic [1:0] cond_sel = 2'd0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic [3:0] offset = 4'd0;
  logic [7:0] target = 8'd0;
  logic       resume = 1'b0;

  logic [7:0] pc, pc_r;
  logic       taken, halted, fault, taken_r, halted_r, fault_r;
  logic [2:0] depth, depth_r;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [2:0] SEQ = 3'd0, SKIP = 3'd1, BRF = 3'd2, BRB = 3'd3;
  localparam logic [2:0] JABS = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;

  pc_sequencer #(.ADDR_W(8), .OFFS_W(4), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset), .enable(enable), .op(op), .cond_sel(cond_sel),
    .zero(zero), .neg(neg), .offset(offset), .target(target), .resume(resume),
    .pc(pc), .taken(taken), .halted(halted), .fault(fault), .stack_depth(depth)
  );

  pc_sequencer #(.ADDR_W(8), .OFFS_W(4), .RAS_DEPTH(4), .RESET_PC(8'h10)) dut_r (
    .clock(clock), .reset(reset), .enable(enable), .op(op), .cond_sel(cond_sel),
    .zero(zero), .neg(neg), .offset(offset), .target(target), .resume(resume),
    .pc(pc_r), .taken(taken_r), .halted(halted_r), .fault(fault_r), .stack_depth(depth_r)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    logic       en;
    logic [2:0] op;
    logic [1:0] cs;
    logic       z;
    logic       n;
    logic [3:0] off;
    logic [7:0] tgt;
    logic       res;
    logic [7:0] e_pc;
    logic       e_tk;
    logic       e_h;
    logic       e_f;
    logic [2:0] e_d;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(bit rst, logic en, logic [2:0] o, logic [1:0] cs, logic z, logic n,
                              logic [3:0] off, logic [7:0] tgt, logic res,
                              logic [7:0] e_pc, logic e_tk, logic e_h, logic e_f, logic [2:0] e_d);
    vec_t v;
    v.rst = rst; v.en = en; v.op = o; v.cs = cs; v.z = z; v.n = n; v.off = off; v.tgt = tgt;
    v.res = res; v.e_pc = e_pc; v.e_tk = e_tk; v.e_h = e_h; v.e_f = e_f; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    enable = v.en; op = v.op; cond_sel = v.cs; zero = v.z; neg = v.n;
    offset = v.off; target = v.tgt; resume = v.res;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    if (v.rst) do_reset();
    else @(negedge clock);
    drive(v);
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard[%0d]: queue empty", idx);
    end else begin
      e = exp_q.pop_front();
      chk("pc", idx, pc, e.e_pc);
      chk("taken", idx, 8'(taken), 8'(e.e_tk));
      chk("halted", idx, 8'(halted), 8'(e.e_h));
      chk("fault", idx, 8'(fault), 8'(e.e_f));
      chk("depth", idx, 8'(depth), 8'(e.e_d));
    end
  endtask

  initial begin
    // Group A: sequential, conditional branches, wrap, call/ret, stall, overflow fault
    vecs.push_back(mk(1, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'd1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'd2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'd3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'd4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'd5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, JABS, 0, 0, 0, 0, 8'd20, 0, 8'd20, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, BRF,  1, 1, 0, 5, 8'h00, 0, 8'd25, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, BRB,  3, 1, 0, 3, 8'h00, 0, 8'd26, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, BRF,  2, 0, 1, 4, 8'h00, 0, 8'd30, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, BRB,  1, 0, 0, 2, 8'h00, 0, 8'd31, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, JABS, 1, 0, 0, 0, 8'h80, 0, 8'd32, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SKIP, 3, 0, 0, 0, 8'h00, 0, 8'd34, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, SKIP, 2, 0, 0, 0, 8'h00, 0, 8'd35, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, JABS, 0, 0, 0, 0, 8'hFE, 0, 8'hFE, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, SKIP, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'h02, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, BRB,  0, 0, 0, 5, 8'h00, 0, 8'hFD, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'hFE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, JABS, 0, 0, 0, 0, 8'h03, 0, 8'h03, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, CALL, 0, 0, 0, 0, 8'h40, 0, 8'h40, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, RET,  0, 0, 0, 0, 8'h00, 0, 8'h04, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, JABS, 0, 0, 0, 0, 8'h77, 0, 8'h04, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, CALL, 0, 0, 0, 0, 8'h10, 0, 8'h10, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, CALL, 0, 0, 0, 0, 8'h20, 0, 8'h20, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, CALL, 0, 0, 0, 0, 8'h30, 0, 8'h30, 1, 0, 0, 3));
    vecs.push_back(mk(0, 1, CALL, 0, 0, 0, 0, 8'h50, 0, 8'h50, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, CALL, 0, 0, 0, 0, 8'h60, 0, 8'h50, 0, 0, 1, 4));
    vecs.push_back(mk(0, 1, JABS, 0, 0, 0, 0, 8'h99, 0, 8'h50, 0, 0, 1, 4));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 1, 8'h50, 0, 0, 1, 4));
    // Group B: LIFO order, then underflow fault and its stickiness
    vecs.push_back(mk(1, 1, CALL, 0, 0, 0, 0, 8'h10, 0, 8'h10, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, CALL, 0, 0, 0, 0, 8'h20, 0, 8'h20, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, RET,  0, 0, 0, 0, 8'h00, 0, 8'h11, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, RET,  0, 0, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, RET,  0, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 1, 0));
    // Group C: halt, stalled resume, resume
    vecs.push_back(mk(1, 1, JABS, 0, 0, 0, 0, 8'h09, 0, 8'h09, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, HALT, 0, 0, 0, 0, 8'h00, 0, 8'h09, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'h09, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, SEQ,  0, 0, 0, 0, 8'h00, 1, 8'h09, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 1, 8'h0A, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ,  0, 0, 0, 0, 8'h00, 0, 8'h0B, 0, 0, 0, 0));

    // Reset state of both instances and the RESET_PC variant's first step
    do_reset();
    #1;
    chk("rst_pc", 0, pc, 8'h00);
    chk("rst_taken", 0, 8'(taken), 8'h00);
    chk("rst_halted", 0, 8'(halted), 8'h00);
    chk("rst_fault", 0, 8'(fault), 8'h00);
    chk("rst_depth", 0, 8'(depth), 8'h00);
    chk("rst_pc_r", 0, pc_r, 8'h10);
    @(negedge clock);
    enable = 1'b1; op = SEQ;
    @(posedge clock);
    #1;
    chk("seq_pc", 0, pc, 8'h01);
    chk("seq_pc_r", 0, pc_r, 8'h11);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset asserted mid-stall clears immediately without a clock edge
    @(negedge clock);
    enable = 1'b0; op = CALL; target = 8'h33;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("async_pc", 0, pc, 8'h00);
    chk("async_pc_r", 0, pc_r, 8'h10);
    chk("async_taken", 0, 8'(taken), 8'h00);
    chk("async_depth", 0, 8'(depth), 8'h00);
    #2;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
